time_slice_gen_multi: RTL
=========================

// Module: time_slice_gen_multi
// PURPOSE
//  Parametrised N-slice time-division window generator for tx_control. Each slice
//  owns a free-running counter advanced by the 1 MHz TSF tick and asserts slice_en
//  while the count is inside its [start,end] window. New features: wrap-around
//  windows, shadowed config with glitch-free commit at period boundary, global
//  resync, and per-slice rising-edge pulses.
// PARAMETERS
//  NUM_SLICE      4   number of slices (1..16)
//  CNT_W          20  counter/config width in bits
//  IDX_W          2   slice index width, >= clog2(NUM_SLICE)
// PORTS
//  clk                  in   1          system clock
//  rstn                 in   1          async active-low reset
//  tsf_pulse_1M         in   1          1-cycle tick, advances all counters
//  slv_reg_wren_signal  in   1          config write strobe
//  cfg_slice_idx        in   IDX_W      slice targeted by write
//  cfg_count_total      in   CNT_W      period-1 (counter wraps after this value)
//  cfg_count_start      in   CNT_W      window first count
//  cfg_count_end        in   CNT_W      window last count
//  resync               in   1          1-cycle: restart all counters at 0
//  slice_en             out  NUM_SLICE  per-slice window enable (registered)
//  slice_start_pulse    out  NUM_SLICE  1-cycle pulse on slice_en 0->1
//  cfg_pending          out  NUM_SLICE  shadow written, not yet committed
// BEHAVIOUR
//  Reset (async, rstn=0): counters 0; active total=start=0, end=all-ones; shadow
//   cleared; cfg_pending=0; slice_en=all-ones (legacy always-on); slice_start_pulse=0.
//  Write: wren=1 & idx<NUM_SLICE -> shadow[idx]<={total,start,end}, pending[idx]<=1.
//   idx>=NUM_SLICE ignored. Re-write while pending overwrites shadow, pending stays 1.
//  Counter i, per cycle, priority order:
//   1 resync=1: cnt<=0; if pending, active<=shadow, pending<=0.
//   2 tsf_pulse_1M & cnt>=total_act: cnt<=0 (wrap); if pending, commit as above.
//   3 tsf_pulse_1M: cnt<=cnt+1.  4 else hold.
//   ">=" compare: counter never runs past total; total=0 gives cnt stuck at 0.
//  Commit never happens mid-period; active config is stable for a whole period.
//  Write and commit same cycle, same slice: commit takes OLD shadow, new value lands
//   in shadow, pending stays 1 (applied next boundary).
//  Window (computed from registered cnt and active config, registered -> slice_en
//   lags counter by 1 cycle):
//   start<=end: en = (cnt>=start)&&(cnt<=end)
//   start> end: en = (cnt>=start)||(cnt<=end)   (wraps across period boundary)
//  slice_start_pulse[i] = slice_en[i] & ~slice_en_d[i], 1 cycle, registered; no pulse
//   out of reset (slice_en_d resets to all-ones).
//  All arithmetic unsigned CNT_W; cnt+1 cannot overflow since cnt<total<=max.
//  rstn asserted mid-period: immediate return to reset values, pending writes lost.
// TESTING
//  T1 reset, no writes, 100 ticks -> slice_en=all-ones, no pulses, cnt stays 0.
//  T2 slice0 total=9,start=2,end=4, resync -> en0 high counts 2..4 (1-cycle lag),
//     period 10 ticks, one start pulse per period, other slices unchanged.
//  T3 slice1 total=9,start=8,end=1 -> en1 high for counts 8,9,0,1; low 2..7.
//  T4 slice0 running, write end=6 at cnt=5 -> pending0=1, en0 unchanged until wrap,
//     next period high 2..6, pending0=0 after commit.
//  T5 write coincident with wrap tick on slice2 -> old shadow committed, pending2
//     stays 1, new value active after following wrap; idx=3 with NUM_SLICE=3 ignored.
//  T6 rstn pulsed mid-period with pending write -> all outputs to reset values
//     asynchronously, pending cleared; resync asserted with tsf_pulse -> cnt=0.

Source files
------------

// File: rtl/time_slice_gen_multi.sv
// N-slice time-division window generator: per-slice period counters advanced by the
// 1 MHz TSF tick, shadowed window config committed only at a period boundary or resync.
module time_slice_gen_multi #(
  parameter int NUM_SLICE = 4,
  parameter int CNT_W     = 20,
  parameter int IDX_W     = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 tsf_pulse_1M,
  input  logic                 slv_reg_wren_signal,
  input  logic [IDX_W-1:0]     cfg_slice_idx,
  input  logic [CNT_W-1:0]     cfg_count_total,
  input  logic [CNT_W-1:0]     cfg_count_start,
  input  logic [CNT_W-1:0]     cfg_count_end,
  input  logic                 resync,
  output logic [NUM_SLICE-1:0] slice_en,
  output logic [NUM_SLICE-1:0] slice_start_pulse,
  output logic [NUM_SLICE-1:0] cfg_pending
);

  // A window with start > end wraps across the period boundary.
  function automatic logic f_in_window(
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] win_start,
    input logic [CNT_W-1:0] win_end
  );
    if (win_start <= win_end) begin
      return (cnt >= win_start) && (cnt <= win_end);
    end
    return (cnt >= win_start) || (cnt <= win_end);
  endfunction

  genvar g;
  for (g = 0; g < NUM_SLICE; g++) begin : g_slice
    logic [CNT_W-1:0] r_cnt_p0;
    logic [CNT_W-1:0] r_tot_act;
    logic [CNT_W-1:0] r_start_act;
    logic [CNT_W-1:0] r_end_act;
    logic [CNT_W-1:0] r_tot_sh;
    logic [CNT_W-1:0] r_start_sh;
    logic [CNT_W-1:0] r_end_sh;
    logic             r_pending;
    logic             r_en_p1;
    logic             r_pulse_p1;

    logic             w_wr;
    logic             w_wrap;
    logic             w_boundary;
    logic             w_commit;
    logic             w_en;

    // Indices >= NUM_SLICE match no slice, so such writes fall through silently.
    always_comb begin
      w_wr       = slv_reg_wren_signal && (cfg_slice_idx == IDX_W'(g));
      w_wrap     = tsf_pulse_1M && (r_cnt_p0 >= r_tot_act);
      w_boundary = resync || w_wrap;
      w_commit   = w_boundary && r_pending;
      w_en       = f_in_window(r_cnt_p0, r_start_act, r_end_act);
    end

    // Stage p0: period counter
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_cnt_p0 <= '0;
      end else if (w_boundary) begin
        r_cnt_p0 <= '0;
      end else if (tsf_pulse_1M) begin
        r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
      end
    end

    // Commit reads the shadow before this cycle's write lands, so a coincident
    // write stays pending for the next boundary.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_tot_act   <= '0;
        r_start_act <= '0;
        r_end_act   <= '1;
        r_tot_sh    <= '0;
        r_start_sh  <= '0;
        r_end_sh    <= '0;
        r_pending   <= 1'b0;
      end else begin
        if (w_commit) begin
          r_tot_act   <= r_tot_sh;
          r_start_act <= r_start_sh;
          r_end_act   <= r_end_sh;
        end
        if (w_wr) begin
          r_tot_sh   <= cfg_count_total;
          r_start_sh <= cfg_count_start;
          r_end_sh   <= cfg_count_end;
          r_pending  <= 1'b1;
        end else if (w_commit) begin
          r_pending  <= 1'b0;
        end
      end
    end

    // Stage p1: registered window enable and its rising-edge pulse
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_en_p1    <= 1'b1;
        r_pulse_p1 <= 1'b0;
      end else begin
        r_en_p1    <= w_en;
        r_pulse_p1 <= w_en & ~r_en_p1;
      end
    end

    assign slice_en[g]          = r_en_p1;
    assign slice_start_pulse[g] = r_pulse_p1;
    assign cfg_pending[g]       = r_pending;
  end

endmodule
